// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch/data requester bundle between processor and mem_ctrl
interface mem_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic              iReq;
  logic [AWIDTH-1:0] iAddr;
  logic              iAck;
  logic [DWIDTH-1:0] iData;
  logic              iErr;
  logic              dReq;
  logic              dWe;
  logic [AWIDTH-1:0] dAddr;
  logic [DWIDTH-1:0] dWData;
  logic              dAck;
  logic [DWIDTH-1:0] dRData;
  logic              dErr;

  // Processor side: issues requests, consumes acks
  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWData,
    input  iAck, iData, iErr, dAck, dRData, dErr
  );

  // Controller side
  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWData,
    output iAck, iData, iErr, dAck, dRData, dErr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - round-robin fetch/data arbiter sequencing a single-port tri-state RAM (optional MEMCTRL_BOUNDS_CHECK_EN)
module mem_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int MEMDEPTH = 1024
) (
  input  logic              clk,
  input  logic              rstN,
  mem_ctrl_if.slave         bus,
  output logic [AWIDTH-1:0] addr,
  output logic              rdEn,
  output logic              wrEn,
  inout  wire  [DWIDTH-1:0] data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              latch_en;
  logic              pick_d;
  logic              gnt_q;      // 1 = data port owns the current access
  logic              last_q;     // 1 = data port won the previous grant
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DWIDTH-1:0] wdata_q;
  logic              oob_q, oob_d;
  logic [DWIDTH-1:0] iData_q;
  logic [DWIDTH-1:0] dRData_q;

  // Round-robin pick: on a tie the port that did not win last time goes first
  always_comb begin
    pick_d = bus.dReq && (!bus.iReq || !last_q);
    addr_d = pick_d ? bus.dAddr : bus.iAddr;
    we_d   = pick_d && bus.dWe;
  end

`ifdef MEMCTRL_BOUNDS_CHECK_EN
  // Out-of-range accesses skip the RAM and complete with an error
  always_comb begin
    oob_d = 32'(addr_d) >= 32'(MEMDEPTH);
  end
`else
  // No bounds checking: every address goes to the RAM
  always_comb begin
    oob_d = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; requests are only looked at while IDLE
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iReq || bus.dReq) begin
          latch_en = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request so later input changes cannot disturb the access
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
    end else if (latch_en) begin
      gnt_q   <= pick_d;
      last_q  <= pick_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= bus.dWData;
      oob_q   <= oob_d;
    end
  end

  // Capture read data at the edge closing ACCESS; skipped accesses return zero
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      iData_q  <= '0;
      dRData_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (gnt_q) dRData_q <= oob_q ? '0 : data;
      else       iData_q  <= oob_q ? '0 : data;
    end
  end

  // RAM strobes decode straight from state so reset removes them at once;
  // the bus is driven only under wrEn, which excludes rdEn
  assign addr = addr_q;
  assign rdEn = (state_q == ACCESS) && !we_q && !oob_q;
  assign wrEn = (state_q == ACCESS) &&  we_q && !oob_q;
  assign data = wrEn ? wdata_q : 'z;

  assign bus.iAck   = (state_q == DONE) && !gnt_q;
  assign bus.dAck   = (state_q == DONE) &&  gnt_q;
  assign bus.iErr   = bus.iAck && oob_q;
  assign bus.dErr   = bus.dAck && oob_q;
  assign bus.iData  = iData_q;
  assign bus.dRData = dRData_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed vector bench for mem_ctrl with a behavioural RAM
module tb_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rstN;
  logic [AW-1:0] addr;
  logic          rdEn;
  logic          wrEn;
  wire  [DW-1:0] data;

  mem_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEMDEPTH(512)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave),
    .addr (addr),
    .rdEn (rdEn),
    .wrEn (wrEn),
    .data (data)
  );

  logic [DW-1:0] mem [0:1023];
  logic          load_ram;

  assign data = rdEn ? mem[addr] : 'z;

  always @(posedge clk) begin
    if (load_ram) begin
      mem[10'h000] <= 32'h1234_5678;
      mem[10'h005] <= 32'h5555_5555;
      mem[10'h010] <= 32'h0000_0000;
      mem[10'h1FF] <= 32'h0BAD_01FF;
      mem[10'h200] <= 32'hCAFE_0200;
    end else if (wrEn) begin
      mem[addr] <= data;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;
  int overlap_cnt;
  int dual_ack_cnt;

  always @(negedge clk) begin
    if (rdEn && wrEn) overlap_cnt++;
    if (bus.iAck && bus.dAck) dual_ack_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            exp_rdc;
    int            exp_wrc;
  } vec_t;

  vec_t vecs [8];

  task automatic do_access(input logic is_d, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                           output logic err, output int cyc, output int rdc,
                           output int wrc, output int other);
    logic got;
    got = 1'b0; cyc = 0; rdc = 0; wrc = 0; other = 0; rd = '0; err = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin
      bus.dReq = 1'b1; bus.dWe = we; bus.dAddr = a; bus.dWData = wd;
    end else begin
      bus.iReq = 1'b1; bus.iAddr = a;
    end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rdEn) rdc++;
      if (wrEn) wrc++;
      if (is_d ? bus.iAck : bus.dAck) other++;
      if (is_d ? bus.dAck : bus.iAck) begin
        got = 1'b1;
        rd  = is_d ? bus.dRData : bus.iData;
        err = is_d ? bus.dErr : bus.iErr;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
    end
    @(posedge clk); #1;
    bus.dReq = 1'b0; bus.iReq = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          err;
  int            cyc, rdc, wrc, other;
  int            order [4];
  int            at    [4];
  int            n_ack;
  int            cnt;

  initial begin
    checks = 0; failures = 0; overlap_cnt = 0; dual_ack_cnt = 0;
    bus.iReq = 1'b0; bus.iAddr = '0; bus.dReq = 1'b0; bus.dWe = 1'b0;
    bus.dAddr = '0; bus.dWData = '0;
    load_ram = 1'b1;
    rstN = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1};
    vecs[1] = '{1'b1, 1'b0, 10'h010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 0};
    vecs[2] = '{1'b0, 1'b0, 10'h000, 32'h0,         32'h1234_5678, 1'b0, 1, 0};
    vecs[3] = '{1'b1, 1'b1, 10'h003, 32'hA5A5_0003, 32'hDEAD_BEEF, 1'b0, 0, 1};
    vecs[4] = '{1'b0, 1'b0, 10'h003, 32'h0,         32'hA5A5_0003, 1'b0, 1, 0};
`ifdef MEMCTRL_BOUNDS_CHECK_EN
    vecs[5] = '{1'b1, 1'b0, 10'h200, 32'h0,         32'h0000_0000, 1'b1, 0, 0};
`else
    vecs[5] = '{1'b1, 1'b0, 10'h200, 32'h0,         32'hCAFE_0200, 1'b0, 1, 0};
`endif
    vecs[6] = '{1'b1, 1'b1, 10'h004, 32'h0404_0404, 32'h0,         1'b0, 0, 1};
    vecs[7] = '{1'b0, 1'b0, 10'h1FF, 32'h0,         32'h0BAD_01FF, 1'b0, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_iAck", {31'b0, bus.iAck}, 32'h0);
    check("reset_dAck", {31'b0, bus.dAck}, 32'h0);
    check("reset_strobes", {30'b0, rdEn, wrEn}, 32'h0);
    check("reset_addr", {22'b0, addr}, 32'h0);
    check("reset_dRData", bus.dRData, 32'h0);
    load_ram = 1'b0;
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].is_d, vecs[i].we, vecs[i].a, vecs[i].wd, rd, err, cyc, rdc, wrc, other);
      check($sformatf("v%0d_latency", i), cyc, 3);
      check($sformatf("v%0d_rdEn_cycles", i), rdc, vecs[i].exp_rdc);
      check($sformatf("v%0d_wrEn_cycles", i), wrc, vecs[i].exp_wrc);
      check($sformatf("v%0d_other_ack", i), other, 0);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    check("mem_0x010_written", mem[10'h010], 32'hDEAD_BEEF);
    check("dRData_held_after_store", bus.dRData, vecs[5].exp_rd);

    // Both ports held: previous grant was I, so expect D,I,D,I every 3 cycles
    @(posedge clk); #1;
    bus.iReq = 1'b1; bus.iAddr = 10'h000;
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 10'h010;
    n_ack = 0; cnt = 0;
    while (n_ack < 4 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus.dAck || bus.iAck) begin
        order[n_ack] = bus.dAck ? 1 : 0;
        at[n_ack] = cnt;
        if (bus.dAck) check("tie_dRData", bus.dRData, 32'hDEAD_BEEF);
        else          check("tie_iData", bus.iData, 32'h1234_5678);
        n_ack++;
      end
    end
    @(posedge clk); #1;
    bus.iReq = 1'b0; bus.dReq = 1'b0;
    check("tie_ack_count", n_ack, 4);
    if (n_ack == 4) begin
      check("tie_grant0_D", order[0], 1);
      check("tie_grant1_I", order[1], 0);
      check("tie_grant2_D", order[2], 1);
      check("tie_grant3_I", order[3], 0);
      check("tie_gap1", at[1] - at[0], 3);
      check("tie_gap2", at[2] - at[1], 3);
      check("tie_gap3", at[3] - at[2], 3);
    end
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.iAck || bus.dAck) cnt++;
    end
    check("tie_no_extra_ack", cnt, 0);

    // dReq held one cycle past dAck yields a second identical access
    @(posedge clk); #1;
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 10'h010;
    n_ack = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.dAck) begin
        check($sformatf("hold_ack%0d_data", n_ack), bus.dRData, 32'hDEAD_BEEF);
        n_ack++;
        if (n_ack == 1) begin
          @(posedge clk); @(posedge clk); #1;
          bus.dReq = 1'b0;
        end
      end
    end
    bus.dReq = 1'b0;
    check("hold_two_acks", n_ack, 2);

    // Reset in the middle of a store to 0x005
    @(posedge clk); #1;
    bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 10'h005; bus.dWData = 32'hFFFF_0005;
    @(negedge clk);
    @(negedge clk);
    check("rst_store_wrEn_before", {31'b0, wrEn}, 32'h1);
    #1 rstN = 1'b0;
    #1;
    check("rst_async_wrEn", {31'b0, wrEn}, 32'h0);
    check("rst_async_rdEn", {31'b0, rdEn}, 32'h0);
    check("rst_async_addr", {22'b0, addr}, 32'h0);
    check("rst_async_dAck", {31'b0, bus.dAck}, 32'h0);
    bus.dReq = 1'b0; bus.dWe = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    check("rst_mem_unchanged", mem[10'h005], 32'h5555_5555);
    do_access(1'b1, 1'b0, 10'h005, 32'h0, rd, err, cyc, rdc, wrc, other);
    check("post_rst_latency", cyc, 3);
    check("post_rst_rdata", rd, 32'h5555_5555);

    check("no_rdEn_wrEn_overlap", overlap_cnt, 0);
    check("no_dual_ack", dual_ack_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory bus controller directly upstream of the single-port RAM.
- Arbitrates between the processor's instruction-fetch port (read-only) and data port (load/store).
- Sequences each access onto the RAM's shared tri-state data bus (addr, rdEn, wrEn, data) so that rdEn and bus drive never overlap.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- DWIDTH, 32, data word width; matches RAM data bus.
- AWIDTH, 10, word-address width; matches RAM addr.
- MEMDEPTH, 1024, number of implemented RAM words; used only by the bounds check.

Ports:
- clk  input  1  system clock, all state on rising edge
- rstN  input  1  asynchronous active-low reset
- iReq  input  1  fetch request, held until iAck
- iAddr  input  AWIDTH  fetch word address
- iAck  output  1  one-cycle fetch completion pulse
- iData  output  DWIDTH  fetched word, valid while iAck=1
- iErr  output  1  fetch error, valid while iAck=1
- dReq  input  1  data request, held until dAck
- dWe  input  1  1=store, 0=load
- dAddr  input  AWIDTH  data word address
- dWData  input  DWIDTH  store data
- dAck  output  1  one-cycle data completion pulse
- dRData  output  DWIDTH  load data, valid while dAck=1
- dErr  output  1  data error, valid while dAck=1
- addr  output  AWIDTH  RAM address
- rdEn  output  1  RAM read enable
- wrEn  output  1  RAM write enable
- data  inout  DWIDTH  RAM shared data bus

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low, on rstN.
  - While rstN=0: state=IDLE, all outputs 0, and data is released to Z immediately, including mid-access.
  - lastGrant resets to I, so D wins the first tie.
- States: IDLE -> ACCESS -> DONE -> IDLE. Every access takes exactly 3 cycles; throughput is 1 access per 3 cycles.
- IDLE:
  - iReq and dReq are sampled only in this state.
  - If any request is present, latch winner, address, we and wdata into internal registers, then go to ACCESS.
  - If none, stay.
- Arbitration: round-robin.
  - If both request, grant the port not in lastGrant.
  - A single request is granted directly.
  - lastGrant updates on every grant.
- ACCESS, read (fetch or load):
  - addr=latched address, rdEn=1, wrEn=0, data=Z.
  - At the closing edge, capture data into the read register for the granted port.
- ACCESS, write (store):
  - addr=latched address, rdEn=0, wrEn=1, data driven with latched wdata.
  - RAM writes at the closing edge.
- DONE:
  - rdEn=wrEn=0, data=Z.
  - Assert the granted port's ack for exactly this cycle, together with its rdata/err.
  - The other port's ack stays 0.
  - Next state is IDLE.
- Requester contract: req must be held from assertion through its ack cycle and deasserted on the edge that ends the ack cycle. If req is still high in the following IDLE, it is a new request.
- Outputs iData/dRData hold their last captured value between acks. Stores do not alter dRData.
- The bus is driven only in ACCESS with a write. rdEn=1 and local drive never coincide.
- Request inputs that change while not IDLE are ignored; the latched copies are used.
- addr holds its last value outside ACCESS; rdEn/wrEn are 0 outside ACCESS.

Optional Feature:
- Macro: MEMCTRL_BOUNDS_CHECK_EN.
- Defined: in IDLE, a granted address >= MEMDEPTH skips the RAM cycle.
  - ACCESS still lasts one cycle, but with rdEn=wrEn=0 and data=Z.
  - DONE then pulses ack with err=1 and rdata=0; the RAM is unchanged.
  - In-range accesses report err=0.
- Undefined: no comparison logic. iErr and dErr are tied to 0, and addresses pass through unchecked.

Test Plan:
- Reset mid-ACCESS of a store to 0x005: drop rstN -> data goes Z, wrEn=0 asynchronously, mem[0x005] unchanged, state IDLE after release.
- Store 0xDEADBEEF to 0x010, then load 0x010 -> wrEn high exactly one cycle, dAck pulses in cycle 3 of each access, dRData=0xDEADBEEF, dErr=0.
- Fetch from 0x000 with mem[0]=0x12345678 -> rdEn=1 only in ACCESS, data never driven by the controller, iAck one cycle with iData=0x12345678.
- iReq and dReq asserted together and held for 4 accesses -> grants alternate D,I,D,I; acks are 3 cycles apart and never simultaneous.
- Requester holds dReq one cycle past dAck -> a second identical access is performed (two dAck pulses).
- With MEMCTRL_BOUNDS_CHECK_EN, MEMDEPTH=512, load 0x200 -> rdEn/wrEn stay 0, dAck with dErr=1 and dRData=0. Without the macro -> normal read and dErr=0.
